deframing: RTL

Receive-side counterpart of the framing stage. It accepts whole frames of FRAME_LEN elements on a valid/last stream, for example from the inverse FFT, and scales and saturates each element to O_BW bits. Frames are buffered in a two-bank ping-pong memory and re-emitted as a continuous one-element-per-CADENCE_CYC stream for downstream time-domain logic. Malformed or overflowing frames are dropped and flagged.

---
 rtl/deframing_pkg.sv | 32 +++
 rtl/deframing_pingpong_ram.sv | 39 +++
 rtl/deframing.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/deframing_pkg.sv
// Shared types and helpers for the deframing block: write/read FSM states,
// bank count and the scale-and-saturate function applied on the write path.
package deframing_pkg;

    localparam int BANKS = 2;

    typedef enum logic {
        WR_RECV = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_UNLOAD = 1'b1
    } rd_state_e;

    // x is the input element sign-extended to 32 bits; result fits o_bw signed bits.
    function automatic logic signed [31:0] sat_shift(input logic signed [31:0] x,
                                                     input int shift,
                                                     input int o_bw);
        logic signed [31:0] v;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        v  = x >>> shift;
        hi = (32'sd1 <<< (o_bw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (o_bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/deframing_pingpong_ram.sv
// Two-bank frame buffer addressed by {bank, ptr}: one write port and one
// registered read port whose output register holds its value between reads.
module deframing_pingpong_ram
    import deframing_pkg::*;
#(
    parameter int O_BW      = 9,
    parameter int FRAME_LEN = 256,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   we_i,
    input  logic [AW:0]            waddr_i,
    input  logic signed [O_BW-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [AW:0]            raddr_i,
    output logic signed [O_BW-1:0] rdata_o
);

    logic signed [O_BW-1:0] mem_q [BANKS*FRAME_LEN];
    logic signed [O_BW-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[raddr_i];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/deframing.sv
// Frame receiver: scales/saturates input frames into a ping-pong buffer and
// replays each committed frame as one element every CADENCE_CYC cycles.
module deframing
    import deframing_pkg::*;
#(
    parameter int I_BW        = 16,
    parameter int O_BW        = 9,
    parameter int FRAME_LEN   = 256,
    parameter int CADENCE_CYC = 3,
    parameter int SHIFT       = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic signed [I_BW-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic signed [O_BW-1:0] data_o,
    output logic                   valid_o,
    output logic                   last_o,
    output logic                   err_o
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(CADENCE_CYC + 1);
    localparam logic [AW-1:0] PTR_LAST   = AW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CADENCE_CYC - 1);

    wr_state_e         wr_state_d, wr_state_q;
    logic              wr_bank_d, wr_bank_q;
    logic [AW-1:0]     wr_ptr_d, wr_ptr_q;
    logic [BANKS-1:0]  full_d, full_q;
    logic              err_p_d, err_p_q, err_o_q;
    rd_state_e         rd_state_d, rd_state_q;
    logic              rd_bank_d, rd_bank_q;
    logic [AW-1:0]     rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic              valid_d, valid_q, last_d, last_q;
    logic              we, re, commit, release_bank;
    logic signed [O_BW-1:0] wdata;

    assign wdata = O_BW'(sat_shift(32'(data_i), SHIFT, O_BW));

    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        err_p_d    = 1'b0;
        we         = 1'b0;
        commit     = 1'b0;
        case (wr_state_q)
            WR_RECV: begin
                if (valid_i) begin
                    // A frame may only start into an empty bank; otherwise drop it whole.
                    if (wr_ptr_q == '0 && full_q[wr_bank_q]) begin
                        err_p_d = 1'b1;
                        if (!last_i) wr_state_d = WR_DROP;
                    end else begin
                        we = 1'b1;
                        if (last_i) begin
                            wr_ptr_d = '0;
                            if (wr_ptr_q == PTR_LAST) begin
                                commit    = 1'b1;
                                wr_bank_d = ~wr_bank_q;
                            end else begin
                                err_p_d = 1'b1;
                            end
                        end else if (wr_ptr_q == PTR_LAST) begin
                            wr_ptr_d   = '0;
                            err_p_d    = 1'b1;
                            wr_state_d = WR_DROP;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (valid_i && last_i) begin
                    wr_state_d = WR_RECV;
                    wr_ptr_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_bank_d    = rd_bank_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        re           = 1'b0;
        release_bank = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = RD_UNLOAD;
                    rd_ptr_d   = '0;
                    cnt_d      = '0;
                end
            end
            RD_UNLOAD: begin
                if (cnt_q == '0) begin
                    re       = 1'b1;
                    cnt_d    = CNT_RELOAD;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == PTR_LAST) begin
                        release_bank = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        if (!full_q[~rd_bank_q]) rd_state_d = RD_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (commit)       full_d[wr_bank_q] = 1'b1;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
        valid_d = re;
        last_d  = re && (rd_ptr_q == PTR_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state_q <= WR_RECV;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            full_q     <= '0;
            err_p_q    <= 1'b0;
            err_o_q    <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            err_p_q    <= err_p_d;
            err_o_q    <= err_p_q;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    deframing_pingpong_ram #(
        .O_BW      (O_BW),
        .FRAME_LEN (FRAME_LEN),
        .AW        (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (we),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i ({rd_bank_q, rd_ptr_q}),
        .rdata_o (data_o)
    );

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_o_q;

endmodule
